// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq
// Column-serial AES-128 InvMixColumns stage for the decryption datapath.
// A 128-bit state is latched on the input handshake and transformed in place
// COLS_PER_CYCLE columns per clock. The finished block is presented on a
// registered valid/ready output. The output handshake and the next input
// handshake may complete on the same edge, so a held-ready consumer sees one
// block every 4/COLS_PER_CYCLE+1 cycles.
// Byte layout: column c occupies bits [127-32c -: 32], and row 0 is the MSB
// byte of each column.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] IN_DATA,
    input  logic         IN_VALID,
    output logic         IN_READY,
    output logic [127:0] OUT_DATA,
    output logic         OUT_VALID,
    input  logic         OUT_READY
);

    // Only 1, 2 or 4 columns per cycle divide the 4-column state evenly.
    generate
        if (!((COLS_PER_CYCLE == 1) || (COLS_PER_CYCLE == 2) || (COLS_PER_CYCLE == 4))) begin : g_bad_cols
            $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // The counter value of the final column group, and the per-cycle counter step.
    // For the 4-column case the step is never used, because every cycle is the final group.
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE % 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_r;
    logic [1:0]   col_cnt_r;
    logic [127:0] work_r;
    logic [127:0] out_data_r;
    logic         out_valid_r;

    logic [127:0] work_next_s;
    logic         last_group_s;
    logic         in_ready_s;

    // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] v);
        xtime = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by 0x09 = x^3 + 1.
    function automatic logic [7:0] gmul9(input logic [7:0] v);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(v);
        x4 = xtime(x2);
        x8 = xtime(x4);
        gmul9 = x8 ^ v;
    endfunction

    // Multiply by 0x0b = x^3 + x + 1.
    function automatic logic [7:0] gmul11(input logic [7:0] v);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(v);
        x4 = xtime(x2);
        x8 = xtime(x4);
        gmul11 = x8 ^ x2 ^ v;
    endfunction

    // Multiply by 0x0d = x^3 + x^2 + 1.
    function automatic logic [7:0] gmul13(input logic [7:0] v);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(v);
        x4 = xtime(x2);
        x8 = xtime(x4);
        gmul13 = x8 ^ x4 ^ v;
    endfunction

    // Multiply by 0x0e = x^3 + x^2 + x.
    function automatic logic [7:0] gmul14(input logic [7:0] v);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(v);
        x4 = xtime(x2);
        x8 = xtime(x4);
        gmul14 = x8 ^ x4 ^ x2;
    endfunction

    // InvMixColumns on one 32-bit column, with row 0 in the MSB byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
        b1 = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
        b2 = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
        b3 = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
        inv_mix_col = {b0, b1, b2, b3};
    endfunction

    // Next working register: transform the current column group and keep the other columns.
    always_comb begin
        work_next_s = work_r;
        for (int c = 0; c < 4; c++) begin
            if ((c >= int'(col_cnt_r)) && (c < (int'(col_cnt_r) + COLS_PER_CYCLE))) begin
                work_next_s[127-32*c -: 32] = inv_mix_col(work_r[127-32*c -: 32]);
            end else begin
                work_next_s[127-32*c -: 32] = work_r[127-32*c -: 32];
            end
        end
    end

    // The final column group is being transformed this cycle.
    assign last_group_s = (col_cnt_r == LAST_CNT);

    // Accept new input when idle, or when the finished block leaves on this same edge.
    assign in_ready_s = (state_r == IDLE) || ((state_r == DONE) && OUT_READY);

    // Control FSM, working register and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            col_cnt_r   <= 2'd0;
            work_r      <= 128'd0;
            out_data_r  <= 128'd0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (IN_VALID) begin
                        work_r    <= IN_DATA;
                        col_cnt_r <= 2'd0;
                        state_r   <= BUSY;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                BUSY: begin
                    work_r <= work_next_s;
                    if (last_group_s) begin
                        out_data_r  <= work_next_s;
                        out_valid_r <= 1'b1;
                        col_cnt_r   <= 2'd0;
                        state_r     <= DONE;
                    end else begin
                        col_cnt_r   <= col_cnt_r + CNT_STEP;
                        state_r     <= BUSY;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        out_valid_r <= 1'b0;
                        if (IN_VALID) begin
                            work_r    <= IN_DATA;
                            col_cnt_r <= 2'd0;
                            state_r   <= BUSY;
                        end else begin
                            state_r   <= IDLE;
                        end
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    col_cnt_r   <= 2'd0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_s;
    assign OUT_DATA  = out_data_r;
    assign OUT_VALID = out_valid_r;

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
- Column-serial AES-128 InvMixColumns stage for the decryption datapath.
- Takes a 128-bit state block through a valid/ready handshake and transforms COLS_PER_CYCLE columns per clock.
- Presents the result with valid/ready to the next round's InvShiftRows → INV_SUB_BYTES path.
- Bypassed by the top level in the final round; this block always transforms.

Parameters:
- COLS_PER_CYCLE, 1, columns processed per clock. Legal values: 1, 2, 4. Any other value is a synthesis-time error.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- IN_DATA  input  128  state block. Column c = bits [127-32c -: 32]. Row 0 is the MSB byte of each column.
- IN_VALID  input  1  IN_DATA is valid.
- IN_READY  output  1  block can accept a new state.
- OUT_DATA  output  128  InvMixColumns result, same byte layout as IN_DATA.
- OUT_VALID  output  1  OUT_DATA is valid.
- OUT_READY  input  1  consumer accepts OUT_DATA.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, column counter=0, working register=0, OUT_DATA=0, OUT_VALID=0.
- IN_READY is combinational and resets to 1 via IDLE: IN_READY = (state==IDLE) | (state==DONE & OUT_READY).
- State machine:
  - IDLE: on IN_VALID&IN_READY, latch IN_DATA into the working register, clear the counter, go to BUSY.
  - BUSY: each cycle, replace columns counter .. counter+COLS_PER_CYCLE-1 in place with their transform. Advance the counter by COLS_PER_CYCLE. After the final group, copy the register to OUT_DATA, set OUT_VALID=1, go to DONE.
  - DONE: hold OUT_DATA/OUT_VALID stable until OUT_READY.
    - OUT_READY with no input handshake: clear OUT_VALID, go to IDLE.
    - OUT_READY and IN_VALID in the same cycle: complete both handshakes on one edge. Clear OUT_VALID, latch the new IN_DATA, go to BUSY. No bubble beyond the compute cycles.
- Latency: input handshake at edge k gives OUT_VALID high after edge k+4/COLS_PER_CYCLE (k+4, k+2, k+1).
- Throughput: one block per 4/COLS_PER_CYCLE+1 cycles when OUT_READY is held high.
- IN_DATA is ignored outside accept cycles. Changes to it during BUSY do not affect the result.
- OUT_DATA must not change while OUT_VALID=1 and OUT_READY=0. IN_READY is 0 throughout BUSY.
- Column transform, with a0..a3 = rows 0..3:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- GF(2^8) arithmetic: multiplication modulo x^8+x^4+x^3+x+1 (0x11b), built from xtime chains. xtime(v) = {v[6:0],1'b0} ^ (v[7] ? 8'h1b : 8'h00). All 8-bit, no carries.
- The counter wraps only through the DONE transition. It never exceeds 4-COLS_PER_CYCLE.
- Reset asserted mid-BUSY or mid-DONE:
  - Immediately force IDLE and OUT_VALID=0.
  - The partial block is discarded. No output is emitted for it after reset release.
- X on IN_DATA while not accepting must not propagate to the outputs.

Test Plan:
- FIPS-197 columns: IN_DATA=8e4da1bc_9fdc589d_01010101_c6c6c6c6, OUT_READY=1 → OUT_DATA=db135345_f20a225c_01010101_c6c6c6c6. OUT_VALID rises exactly 4 edges after the accept (COLS_PER_CYCLE=1). Repeat with COLS_PER_CYCLE=2 and 4: latencies 2 and 1, identical data.
- Round-trip: MixColumns-encoded d5d5d7d6 in all four columns → d4d4d4d5 in every column. All-zero block → all-zero.
- Backpressure: hold OUT_READY=0 for 10 cycles after OUT_VALID. OUT_DATA/OUT_VALID stay stable, IN_READY=0, and a pending IN_VALID is not consumed.
- Back-to-back: IN_VALID held high, two distinct blocks, OUT_READY=1. The second accept coincides with the first output handshake. Outputs are correct and in order, with a 5-cycle period (COLS_PER_CYCLE=1).
- Reset mid-operation: pull rst_n low asynchronously (between clock edges) two cycles after accept. OUT_VALID=0 and IN_READY=1 immediately. After release, no stale output appears. The next block is processed correctly.
- Input isolation: change IN_DATA every cycle during BUSY → output matches the block latched at accept.
